// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time to
// instruction memory, queues returned words and hands them to IF/ID.
module fetch_stage #(
  parameter int ADD_INST_SIZE = 8,
  parameter int SIZE_DATA     = 32,
  parameter int VALOR_SUMADO  = 4,
  parameter int RESET_PC      = 0,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     imem_req,
  output logic [ADD_INST_SIZE-1:0] imem_addr,
  input  logic                     imem_valid,
  input  logic [SIZE_DATA-1:0]     imem_data,
  input  logic                     redirect,
  input  logic [ADD_INST_SIZE-1:0] redirect_pc,
  input  logic                     if_ready,
  output logic                     if_valid,
  output logic [SIZE_DATA-1:0]     if_instr,
  output logic [ADD_INST_SIZE-1:0] if_pc,
  output logic [ADD_INST_SIZE-1:0] if_pc_next
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADD_INST_SIZE-1:0] PC_INC     = ADD_INST_SIZE'(VALOR_SUMADO);
  localparam logic [ADD_INST_SIZE-1:0] PC_RST     = ADD_INST_SIZE'(RESET_PC);
  localparam logic [ADD_INST_SIZE-1:0] ALIGN_MASK = ~ADD_INST_SIZE'(3);
  localparam logic [CW-1:0]            DEPTH_C    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,  // nothing outstanding
    S_WAIT    = 2'd1,  // one request outstanding, response will be kept
    S_DISCARD = 2'd2   // one request outstanding, response will be dropped
  } state_t;

  state_t state, state_next;

  logic [ADD_INST_SIZE-1:0] pc;
  logic [ADD_INST_SIZE-1:0] req_pc;
  logic [CW-1:0]            count;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;

  logic [SIZE_DATA-1:0]     q_instr   [FIFO_DEPTH];
  logic [ADD_INST_SIZE-1:0] q_pc      [FIFO_DEPTH];
  logic [ADD_INST_SIZE-1:0] q_pc_next [FIFO_DEPTH];

  logic issue;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first, so no path leaves state_next unassigned and
  // no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH: begin
        if (issue) state_next = S_WAIT;
      end
      S_WAIT: begin
        // A redirect turns the outstanding fetch stale, unless it returns now.
        if (redirect)        state_next = imem_valid ? S_FETCH : S_DISCARD;
        else if (imem_valid) state_next = S_FETCH;
      end
      S_DISCARD: begin
        if (imem_valid) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and queue control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // Queue slot is reserved at issue time, so a kept response always fits.
    issue     = reset_n && (state == S_FETCH) && (count < DEPTH_C) && !redirect;
    imem_req  = issue;
    imem_addr = pc;
    push      = (state == S_WAIT) && imem_valid && !redirect;
    pop       = (count != '0) && if_ready && !redirect;
  end

  // ---------------------------------------------------------------------------
  // PC, request address and instruction queue
  // ---------------------------------------------------------------------------
  // NOTE: the queue storage is reset as well, because the head entry drives the
  // IF/ID outputs directly and those must read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= PC_RST;
      req_pc <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_instr[i]   <= '0;
        q_pc[i]      <= '0;
        q_pc_next[i] <= '0;
      end
    end else if (redirect) begin
      // Flush wins over any same-cycle push or pop.
      pc     <= redirect_pc & ALIGN_MASK;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (issue) begin
        pc     <= pc + PC_INC;
        req_pc <= pc;
      end
      if (push) begin
        q_instr[wr_ptr]   <= imem_data;
        q_pc[wr_ptr]      <= req_pc;
        q_pc_next[wr_ptr] <= req_pc + PC_INC;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign if_valid   = (count != '0);
  assign if_instr   = q_instr[rd_ptr];
  assign if_pc      = q_pc[rd_ptr];
  assign if_pc_next = q_pc_next[rd_ptr];

endmodule
